// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------+
// | mult_pkg : shared helpers for the mult_pipe_hs multiplier pipeline   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  localparam int EXT_W = 64;

  function automatic int prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  // Extends the low 'width' bits of value to width+1 bits; bits above are fill.
  function automatic logic [EXT_W:0] ext_operand(input logic [EXT_W-1:0] value,
                                                 input logic             signed_flag,
                                                 input int               width);
    logic [EXT_W:0] r;
    logic           msb;
    logic           fill;
    msb = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i == width - 1) msb = value[i];
    end
    fill = signed_flag & msb;
    r    = '0;
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < width) ? value[i] : fill;
    end
    r[EXT_W] = fill;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_pipe_stage.sv
// +----------------------------------------------------------------------+
// | mult_pipe_stage : one valid/enable register stage, generic payload   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Flush drops the valid bit only; payload keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/mult_pipe_hs.sv
// +----------------------------------------------------------------------+
// | mult_pipe_hs : pipelined mixed-sign multiplier, valid/ready on both  |
// | sides, tag passthrough, synchronous flush. Revision : 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_pipe_hs
  import mult_pkg::*;
#(
  parameter int WIDTHA         = 16,
  parameter int WIDTHB         = 24,
  parameter int PIPELINE_DEPTH = 4,
  parameter int TAG_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTHA-1:0]        in_a,
  input  logic [WIDTHB-1:0]        in_b,
  input  logic                     in_a_signed,
  input  logic                     in_b_signed,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTHA+WIDTHB-1:0] out_result,
  output logic                     out_signed,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  localparam int NSTG = PIPELINE_DEPTH + 1;
  localparam int PW   = prod_width(WIDTHA, WIDTHB);
  localparam int WA1  = WIDTHA + 1;
  localparam int WB1  = WIDTHB + 1;
  localparam int S0_W = WIDTHA + WIDTHB + 2 + TAG_W;
  localparam int SN_W = PW + 1 + TAG_W;

  wire  [NSTG-1:0]   v;
  logic [NSTG-1:0]   en;
  logic [S0_W-1:0]   s0_data;
  wire  [SN_W-1:0]   sn_data [1:NSTG-1];

  logic [WIDTHA-1:0] a_s0;
  logic [WIDTHB-1:0] b_s0;
  logic              as_s0, bs_s0;
  logic [TAG_W-1:0]  tag_s0;

  logic [WA1-1:0]    a_ext;
  logic [WB1-1:0]    b_ext;
  logic signed [PW-1:0] a_mul, b_mul, prod;

  // A stage may load when it is empty or when the stage ahead of it loads.
  always_comb begin
    logic carry;
    en    = '0;
    carry = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      en[k] = ~v[k] | carry;
      carry = ~v[k] | carry;
    end
  end

  assign in_ready = en[0] & ~rst & ~flush;

  assign {a_s0, b_s0, as_s0, bs_s0, tag_s0} = s0_data;

  // Operands widened by one bit and sign-extended to the product width,
  // so a single signed multiply is exact for every signedness mix.
  assign a_ext = WA1'(ext_operand(EXT_W'(a_s0), as_s0, WIDTHA));
  assign b_ext = WB1'(ext_operand(EXT_W'(b_s0), bs_s0, WIDTHB));
  assign a_mul = PW'($signed(a_ext));
  assign b_mul = PW'($signed(b_ext));
  assign prod  = a_mul * b_mul;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    if (k == 0) begin : g_in
      mult_pipe_stage #(.DATA_W(S0_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .en_i    (en[0]),
        .valid_i (in_valid),
        .data_i  ({in_a, in_b, in_a_signed, in_b_signed, in_tag}),
        .valid_o (v[0]),
        .data_o  (s0_data)
      );
    end else if (k == 1) begin : g_prod
      mult_pipe_stage #(.DATA_W(SN_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .en_i    (en[1]),
        .valid_i (v[0]),
        .data_i  ({prod, as_s0 | bs_s0, tag_s0}),
        .valid_o (v[1]),
        .data_o  (sn_data[1])
      );
    end else begin : g_dly
      mult_pipe_stage #(.DATA_W(SN_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .en_i    (en[k]),
        .valid_i (v[k-1]),
        .data_i  (sn_data[k-1]),
        .valid_o (v[k]),
        .data_o  (sn_data[k])
      );
    end
  end

  assign out_valid                          = v[NSTG-1];
  assign {out_result, out_signed, out_tag}  = sn_data[NSTG-1];
  assign busy                               = |v;

endmodule

`default_nettype wire

// File: tb/tb_mult_pipe_hs.sv
// +----------------------------------------------------------------------+
// | tb_mult_pipe_hs : self-checking bench for mult_pipe_hs               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_pipe_hs;

  localparam int WA    = 16;
  localparam int WB    = 24;
  localparam int DEPTH = 4;
  localparam int TW    = 8;
  localparam int NSTG  = DEPTH + 1;
  localparam int PW    = WA + WB;

  logic          clk;
  logic          rst, flush;
  logic          in_valid, in_ready;
  logic [WA-1:0] in_a;
  logic [WB-1:0] in_b;
  logic          in_a_signed, in_b_signed;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_result;
  logic          out_signed;
  logic [TW-1:0] out_tag;
  logic          busy;

  mult_pipe_hs #(
    .WIDTHA(WA), .WIDTHB(WB), .PIPELINE_DEPTH(DEPTH), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_a_signed(in_a_signed), .in_b_signed(in_b_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_signed(out_signed), .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          as;
    logic          bs;
    logic [TW-1:0] tag;
    logic [PW-1:0] res;
  } vec_t;

  typedef struct {
    logic [PW-1:0] res;
    logic          sgn;
    logic [TW-1:0] tag;
    int            acc_cyc;
  } sb_t;

  vec_t vt[8];
  sb_t  q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;
  int acc_total = 0;
  int out_count = 0;
  int last_out_cyc = 0;
  bit chk_lat = 0;
  bit stall_prev = 0;
  logic [PW+TW:0] hold_prev;
  logic [PW-1:0]  nx_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                            input logic as, input logic bs);
    longint av, bv, p;
    av = as ? longint'($signed(a)) : longint'(a);
    bv = bs ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    return p[PW-1:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clock: check handshake/occupancy against the queue model, score outputs.
  task automatic step();
    sb_t e;
    #1;
    check("in_ready", 64'(in_ready), 64'(!rst && !flush && (q.size() < NSTG || out_ready)));
    check("busy", 64'(busy), 64'(q.size() != 0));
    if (stall_prev)
      check("stall_hold", 64'({out_valid, out_result, out_signed, out_tag}), 64'({1'b1, hold_prev}));
    if (q.size() == 0)
      check("idle_out_valid", 64'(out_valid), 64'(0));
    else if (out_valid && out_ready) begin
      e = q.pop_front();
      check("result", 64'({out_result, out_signed, out_tag}), 64'({e.res, e.sgn, e.tag}));
      if (chk_lat) check("latency", 64'(cyc_no - e.acc_cyc), 64'(NSTG));
      out_count++;
      last_out_cyc = cyc_no;
    end
    stall_prev = out_valid && !out_ready && !rst && !flush;
    hold_prev  = {out_result, out_signed, out_tag};
    if (in_valid && in_ready) begin
      q.push_back('{nx_res, in_a_signed | in_b_signed, in_tag, cyc_no});
      acc_total++;
    end
    if (rst || flush) q.delete();
    cyc();
    cyc_no++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic rand_pair();
    in_a        = WA'($urandom);
    in_b        = WB'($urandom);
    in_a_signed = 1'($urandom);
    in_b_signed = 1'($urandom);
    in_tag      = TW'($urandom);
    nx_res      = ref_mul(in_a, in_b, in_a_signed, in_b_signed);
  endtask

  initial begin
    int acc0, out0, t_r, sent, budget;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, out0, t_r, sent, budget;
    vt[0] = '{16'hFFFF, 24'hFFFFFF, 1'b0, 1'b0, 8'h11, 40'hFFFEFF0001};
    vt[1] = '{16'hFFFF, 24'h000003, 1'b1, 1'b1, 8'h22, 40'hFFFFFFFFFD};
    vt[2] = '{16'h8000, 24'hFFFFFF, 1'b1, 1'b0, 8'h33, 40'h8000008000};
    vt[3] = '{16'hFFFF, 24'hFFFFFF, 1'b0, 1'b1, 8'h44, 40'hFFFFFF0001};
    vt[4] = '{16'h8000, 24'h800000, 1'b1, 1'b1, 8'h55, 40'h4000000000};
    vt[5] = '{16'h0000, 24'h123456, 1'b0, 1'b0, 8'h66, 40'h0000000000};
    vt[6] = '{16'h0002, 24'h000003, 1'b0, 1'b0, 8'h77, 40'h0000000006};
    vt[7] = '{16'h7FFF, 24'h7FFFFF, 1'b1, 1'b1, 8'h88, 40'h3FFF7F8001};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0; in_tag = '0; nx_res = '0;

    // Reset state
    cyc();
    step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'({out_result, out_signed, out_tag}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 64'(in_ready), 64'(1));
    step();

    // Table vectors, one at a time, unstalled
    chk_lat   = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = vt[i].a; in_b = vt[i].b; in_a_signed = vt[i].as; in_b_signed = vt[i].bs;
      in_tag = vt[i].tag; nx_res = vt[i].res;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drain(20);
      step();
    end

    // Streaming: 8 back-to-back pairs, tags 0..7
    out0 = out_count;
    for (int i = 0; i < 8; i++) begin
      rand_pair();
      in_tag = TW'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain(20);
    check("stream_count", 64'(out_count - out0), 64'(8));
    chk_lat = 0;

    // Backpressure: exactly NSTG accepts, then drain in order
    out_ready = 1'b0;
    acc0 = acc_total;
    for (int i = 0; i < 8; i++) begin
      rand_pair();
      in_valid = 1'b1;
      step();
    end
    check("bp_accepts", 64'(acc_total - acc0), 64'(NSTG));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    out0 = out_count;
    t_r  = cyc_no;
    drain(20);
    check("bp_drain_count", 64'(out_count - out0), 64'(NSTG));
    check("bp_drain_back2back", 64'(last_out_cyc - t_r), 64'(NSTG - 1));
    acc0 = acc_total;
    rand_pair();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_resume", 64'(acc_total - acc0), 64'(1));
    drain(20);

    // Bubble collapse: two pairs separated by idle cycles end up adjacent
    out_ready = 1'b0;
    rand_pair(); in_valid = 1'b1; step();
    in_valid = 1'b0; step(); step(); step();
    rand_pair(); in_valid = 1'b1; step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b1;
    out0 = out_count;
    t_r  = cyc_no;
    drain(20);
    check("bubble_count", 64'(out_count - out0), 64'(2));
    check("bubble_adjacent", 64'(last_out_cyc - t_r), 64'(1));

    // Flush with 3 pairs in flight
    for (int i = 0; i < 3; i++) begin
      rand_pair(); in_valid = 1'b1; step();
    end
    rand_pair();
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_rdy", 64'(in_ready), 64'(1));
    for (int i = 0; i < 10; i++) step();

    // Reset mid-operation with 3 pairs in flight under backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_pair(); in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_out", 64'({out_valid, out_result, out_signed, out_tag}), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rdy", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Random traffic with random backpressure
    out0   = out_count;
    acc0   = acc_total;
    sent   = 0;
    budget = 0;
    while ((sent < 1000 || q.size() != 0) && budget < 20000) begin
      rand_pair();
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      sent = acc_total - acc0;
      budget++;
    end
    if (budget >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL random_timeout: sent %0d pending %0d", sent, q.size());
    end
    check("random_out_count", 64'(out_count - out0), 64'(1000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
